// File: rtl/yarp_pkg.sv
// Shared types for the yarp core and its data-memory responder.
package yarp_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } mem_access_size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    localparam int unsigned DMEM_WS_W = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/yarp_dmem_responder_if.sv
// Core <-> data-memory request/grant/response bundle.
interface yarp_dmem_responder_if;

    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_wr_i;
    logic [1:0]  data_byte_i;
    logic [31:0] data_wr_data_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rd_data_o;
    logic        data_err_o;

    modport master (
        output data_req_i, data_addr_i, data_wr_i, data_byte_i, data_wr_data_i,
        input  data_gnt_o, data_rvalid_o, data_rd_data_o, data_err_o
    );

    modport slave (
        input  data_req_i, data_addr_i, data_wr_i, data_byte_i, data_wr_data_i,
        output data_gnt_o, data_rvalid_o, data_rd_data_o, data_err_o
    );

endinterface

// File: rtl/yarp_dmem_lane.sv
// Byte-lane steering for one access: byte enables, store replication, load extraction.
module yarp_dmem_lane
    import yarp_pkg::*;
(
    input  mem_access_size_e size_i,
    input  logic [1:0]       off_i,
    input  logic [31:0]      wdata_i,
    input  logic [31:0]      rword_i,
    output logic [3:0]       be_o,
    output logic [31:0]      wdata_o,
    output logic [31:0]      rdata_o,
    output logic             misalign_o
);

    logic [31:0] rshift;

    assign rshift = rword_i >> {off_i, 3'b000};

    always_comb begin
        be_o       = 4'h0;
        wdata_o    = wdata_i;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        case (size_i)
            BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {24'h0, rshift[7:0]};
            end
            HALF_WORD: begin
                misalign_o = off_i[0];
                be_o       = 4'b0011 << off_i;
                wdata_o    = {2{wdata_i[15:0]}};
                rdata_o    = {16'h0, rshift[15:0]};
            end
            WORD: begin
                misalign_o = (off_i != 2'b00);
                be_o       = 4'hF;
                rdata_o    = rword_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/yarp_dmem_responder.sv
// Data-memory responder: word SRAM with fixed wait states, grant/rvalid handshake,
// lane steering and misalignment/range faults. One request in flight at most.
module yarp_dmem_responder
    import yarp_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic                    clk,
    input logic                    reset_n,
    yarp_dmem_responder_if.slave   dmem
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    dmem_state_e           state_q, state_d;
    logic [DMEM_WS_W-1:0]  cnt_q, cnt_d;
    dmem_req_t             req_q, req_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdat_q, wdat_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic                  cmt_q, cmt_d;
    logic                  gnt_q, gnt_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rerr_q, rerr_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [31:0]           mem_q [DEPTH];

    logic                  accept;
    dmem_req_t             src;
    logic [31:0]           off_addr;
    logic                  in_range;
    logic [AW-1:0]         src_idx;
    logic                  src_fault;
    logic                  commit;
    logic [31:0]           fwd_word;
    logic [3:0]            lane_be;
    logic [31:0]           lane_wdata;
    logic [31:0]           lane_rdata;
    logic                  lane_misalign;

    assign accept = dmem.data_req_i & gnt_q;

    // The request being decoded: the one on the bus when accepted, else the captured one.
    always_comb begin
        src = req_q;
        if (accept) begin
            src.addr  = dmem.data_addr_i;
            src.wr    = dmem.data_wr_i;
            src.size  = dmem.data_byte_i;
            src.wdata = dmem.data_wr_data_i;
        end
    end

    assign off_addr  = src.addr - BASE_ADDR;
    assign in_range  = (src.addr >= BASE_ADDR) && ({1'b0, off_addr} < SPAN);
    assign src_idx   = off_addr[AW+1:2];
    assign src_fault = (src.size == 2'b10) | lane_misalign | ~in_range;
    assign commit    = (state_q == RESP) & cmt_q;

    // A load decoded on the same edge that commits a store must see the stored bytes.
    always_comb begin
        fwd_word = mem_q[src_idx];
        for (int b = 0; b < 4; b++) begin
            if (commit && (idx_q == src_idx) && be_q[b]) begin
                fwd_word[8*b +: 8] = wdat_q[8*b +: 8];
            end
        end
    end

    yarp_dmem_lane u_lane (
        .size_i     (mem_access_size_e'(src.size)),
        .off_i      (src.addr[1:0]),
        .wdata_i    (src.wdata),
        .rword_i    (fwd_word),
        .be_o       (lane_be),
        .wdata_o    (lane_wdata),
        .rdata_o    (lane_rdata),
        .misalign_o (lane_misalign)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        be_d    = be_q;
        wdat_d  = wdat_q;
        idx_d   = idx_q;
        cmt_d   = cmt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    req_d  = src;
                    be_d   = lane_be;
                    wdat_d = lane_wdata;
                    idx_d  = src_idx;
                    cmt_d  = src.wr & ~src_fault;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = DMEM_WS_W'(WAIT_STATES - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - DMEM_WS_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d    = (state_d != WAIT);
        rvalid_d = (state_d == RESP);
        rerr_d   = (state_d == RESP) & src_fault;
        rdata_d  = rdata_q;
        if (state_d == RESP) begin
            rdata_d = (src_fault | src.wr) ? 32'h0 : lane_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= '0;
            be_q     <= '0;
            wdat_q   <= '0;
            idx_q    <= '0;
            cmt_q    <= 1'b0;
            gnt_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            be_q     <= be_d;
            wdat_q   <= wdat_d;
            idx_q    <= idx_d;
            cmt_q    <= cmt_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage survives reset; writes only ever happen from RESP, so a reset drops them.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
                end
            end
        end
    end

    assign dmem.data_gnt_o     = gnt_q;
    assign dmem.data_rvalid_o  = rvalid_q;
    assign dmem.data_err_o     = rerr_q;
    assign dmem.data_rd_data_o = rdata_q;

endmodule
